// File: rtl/cpu_mem_server_pkg.sv
// Shared definitions for cpu_mem_server: FSM state encoding, CPU bus tags
// and the CPU word width.
package cpu_mem_server_pkg;

   localparam int CPU_WORD_W = 6;

   localparam logic [1:0] TAG_ADDR = 2'b00;
   localparam logic [1:0] TAG_OUT  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      RUN  = 2'd2
   } state_e;

endpackage

// File: rtl/cpu_mem_server_fifo.sv
// Synchronous FIFO for captured CPU output words. Pointers carry an extra
// wrap bit so full and empty are distinguishable. The head reads as zero
// while empty. Overflow policy is owned by the parent.
module cpu_mem_server_fifo
   import cpu_mem_server_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  push_i,
   input  logic [CPU_WORD_W-1:0] data_i,
   input  logic                  pop_i,
   output logic [CPU_WORD_W-1:0] data_o,
   output logic                  full_o,
   output logic                  empty_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]           wr_q, wr_d;
   logic [AW:0]           rd_q, rd_d;
   logic [CPU_WORD_W-1:0] mem_q [DEPTH];

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign data_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

   // Advance pointers on accepted push / pop.
   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (push_i) wr_d = wr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_d = rd_q + (AW+1)'(1);
   end

   // Pointer registers; reset empties the FIFO.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage array, written at the tail; contents need no reset.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/cpu_mem_server.sv
// Memory/IO companion for the 6-bit accumulator CPU: combinational program
// store, tagged-output capture FIFO, and CPU reset sequencing.
// Optional watchdog: define CPU_MEM_SERVER_WATCHDOG_EN.
module cpu_mem_server
   import cpu_mem_server_pkg::*;
#(
   parameter int FIFO_DEPTH     = 4,
   parameter int RESET_CYCLES   = 4,
   parameter int MAX_RUN_CYCLES = 1023
)(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] cpu_out,
   output logic [5:0] cpu_mem,
   output logic       cpu_reset,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [5:0] load_addr,
   input  logic [5:0] load_data,
   input  logic       start,
   input  logic       stop,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [5:0] out_data,
   output logic       running,
   output logic       overflow,
   output logic       timeout
);

   localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

   state_e                state_q, state_d;
   logic [HW-1:0]         hold_q, hold_d;
   logic                  ovf_q, ovf_d;
   logic                  tmo_q, tmo_d;
   logic                  wd_expire;
   logic [CPU_WORD_W-1:0] prog_q [64];

   logic fifo_full, fifo_empty;
   logic cap_req, pop, push_ok;

   assign load_ready = (state_q == IDLE);
   assign running    = (state_q == RUN);
   assign cpu_reset  = (state_q != RUN);
   assign overflow   = ovf_q;
   assign timeout    = tmo_q;
   assign out_valid  = !fifo_empty;

   // The CPU samples the fetch on the very next edge, so the read stays unregistered.
   assign cpu_mem = (cpu_out[7:6] == TAG_ADDR) ? prog_q[cpu_out[5:0]] : '0;

   assign cap_req = (state_q == RUN) && (cpu_out[7:6] == TAG_OUT);
   assign pop     = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok = cap_req && (!fifo_full || pop);

   // Program store writes; only accepted while the CPU is parked in IDLE.
   always_ff @(posedge clk) begin
      if (load_valid && load_ready) prog_q[load_addr] <= load_data;
   end

   cpu_mem_server_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push_ok),
      .data_i  (cpu_out[5:0]),
      .pop_i   (pop),
      .data_o  (out_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef CPU_MEM_SERVER_WATCHDOG_EN
   localparam int WW = $clog2(MAX_RUN_CYCLES + 1);
   localparam logic [WW-1:0] WD_LAST = WW'(MAX_RUN_CYCLES - 1);

   logic [WW-1:0] wd_q, wd_d;

   // Run-length counter: held at zero outside RUN, counts every RUN cycle.
   always_comb begin
      wd_d = '0;
      if (state_q == RUN) wd_d = wd_q + WW'(1);
   end

   // Watchdog counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) wd_q <= '0;
      else          wd_q <= wd_d;
   end

   assign wd_expire = (state_q == RUN) && (wd_q == WD_LAST);
`else
   logic unused_cfg;
   assign unused_cfg = (MAX_RUN_CYCLES < 0);
   assign wd_expire  = 1'b0;
`endif

   // Run-control FSM plus sticky status flags.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      ovf_d   = ovf_q;
      tmo_d   = tmo_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = HOLD;
               hold_d  = '0;
               ovf_d   = 1'b0;
               tmo_d   = 1'b0;
            end
         end
         HOLD: begin
            if (stop)                      state_d = IDLE;
            else if (hold_q == HOLD_LAST)  state_d = RUN;
            else                           hold_d  = hold_q + HW'(1);
         end
         RUN: begin
            if (wd_expire) begin
               state_d = IDLE;
               tmo_d   = 1'b1;
            end else if (stop) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      if (cap_req && fifo_full && !pop) ovf_d = 1'b1;
   end

   // Control registers; async reset parks the CPU in reset immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         hold_q  <= '0;
         ovf_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         ovf_q   <= ovf_d;
         tmo_q   <= tmo_d;
      end
   end

endmodule

// File: tb/tb_cpu_mem_server.sv
// Self-checking bench for cpu_mem_server: directed scenarios followed by a
// randomized phase, all checked against a queue/array reference model.
module tb_cpu_mem_server;

   localparam int DEPTH = 4;
   localparam int RC    = 4;
   localparam int MAXC  = 15;
`ifdef CPU_MEM_SERVER_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   localparam int M_IDLE = 0;
   localparam int M_HOLD = 1;
   localparam int M_RUN  = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] cpu_out;
   logic [5:0] cpu_mem;
   logic       cpu_reset;
   logic       load_valid;
   logic       load_ready;
   logic [5:0] load_addr;
   logic [5:0] load_data;
   logic       start;
   logic       stop;
   logic       out_valid;
   logic       out_ready;
   logic [5:0] out_data;
   logic       running;
   logic       overflow;
   logic       timeout;

   cpu_mem_server #(
      .FIFO_DEPTH(DEPTH), .RESET_CYCLES(RC), .MAX_RUN_CYCLES(MAXC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .cpu_out(cpu_out), .cpu_mem(cpu_mem),
      .cpu_reset(cpu_reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data), .start(start), .stop(stop),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .running(running), .overflow(overflow), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Reference model state
   int         m_mode;
   int         m_hold_left;
   int         m_run_cycles;
   bit         m_ovf;
   bit         m_tmo;
   bit         m_loaded;
   logic [5:0] m_mem [64];
   logic [5:0] m_q [$];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_hold_left = 0; m_run_cycles = 0;
      m_ovf = 1'b0; m_tmo = 1'b0;
      m_q.delete();
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int sz;
      bit pop, cap;
      sz  = m_q.size();
      pop = (sz > 0) && out_ready;
      cap = (m_mode == M_RUN) && (cpu_out[7:6] == 2'b10);
      if (pop) void'(m_q.pop_front());
      if (cap) begin
         if (sz < DEPTH || pop) m_q.push_back(cpu_out[5:0]);
         else                   m_ovf = 1'b1;
      end
      if (m_mode == M_IDLE && load_valid) m_mem[load_addr] = load_data;
      case (m_mode)
         M_IDLE: if (start) begin
            m_mode = M_HOLD; m_hold_left = RC; m_ovf = 1'b0; m_tmo = 1'b0;
         end
         M_HOLD: begin
            if (stop) m_mode = M_IDLE;
            else begin
               m_hold_left--;
               if (m_hold_left == 0) begin m_mode = M_RUN; m_run_cycles = 0; end
            end
         end
         default: begin
            m_run_cycles++;
            if (WD_EN && m_run_cycles == MAXC) begin m_tmo = 1'b1; m_mode = M_IDLE; end
            else if (stop) m_mode = M_IDLE;
         end
      endcase
   endtask

   task automatic check_all();
      logic [5:0] exp_fetch;
      chk("cpu_reset",  8'(cpu_reset),  8'(m_mode != M_RUN));
      chk("running",    8'(running),    8'(m_mode == M_RUN));
      chk("load_ready", 8'(load_ready), 8'(m_mode == M_IDLE));
      chk("out_valid",  8'(out_valid),  8'(m_q.size() > 0));
      chk("out_data",   8'(out_data),   (m_q.size() > 0) ? 8'(m_q[0]) : 8'h00);
      chk("overflow",   8'(overflow),   8'(m_ovf));
      chk("timeout",    8'(timeout),    8'(m_tmo));
      if (m_loaded) begin
         exp_fetch = (cpu_out[7:6] == 2'b00) ? m_mem[cpu_out[5:0]] : 6'h00;
         chk("cpu_mem", 8'(cpu_mem), 8'(exp_fetch));
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; load_valid = 1'b0;
      check_all();
   endtask

   initial begin
      logic [7:0] cap_seq [5];
      logic [5:0] drain_exp [4];
      logic [5:0] full_exp [4];

      cap_seq   = '{8'h85, 8'h93, 8'h81, 8'hBF, 8'h80};
      drain_exp = '{6'h05, 6'h13, 6'h01, 6'h3F};
      full_exp  = '{6'h02, 6'h03, 6'h04, 6'h0C};

      reset_n = 1'b0; cpu_out = 8'h40; load_valid = 1'b0; load_addr = '0;
      load_data = '0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
      m_loaded = 1'b0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_all();
      reset_n = 1'b1;
      repeat (2) tick();

      // Load the whole store, then mem[7]=2A, then fetch
      for (int a = 0; a < 64; a++) begin
         load_valid = 1'b1; load_addr = 6'(a); load_data = 6'($urandom);
         tick();
      end
      load_valid = 1'b1; load_addr = 6'd7; load_data = 6'h2A;
      tick();
      m_loaded = 1'b1;
      cpu_out = 8'h07; #1;
      chk("fetch_07", 8'(cpu_mem), 8'h2A);
      cpu_out = 8'h87; #1;
      chk("fetch_tag10", 8'(cpu_mem), 8'h00);
      cpu_out = 8'h00;
      tick();

      // Reset sequencing
      start = 1'b1;
      tick();
      repeat (RC - 1) begin
         tick();
         chk("hold_cpu_reset", 8'(cpu_reset), 8'h01);
      end
      tick();
      chk("release_cpu_reset", 8'(cpu_reset), 8'h00);
      chk("release_running", 8'(running), 8'h01);
      repeat (5) tick();
      stop = 1'b1;
      tick();
      chk("stop_cpu_reset", 8'(cpu_reset), 8'h01);

      // Capture with backpressure
      start = 1'b1;
      tick();
      repeat (RC) tick();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cpu_out = cap_seq[i];
         tick();
      end
      cpu_out = 8'h40;
      tick();
      chk("cap_overflow", 8'(overflow), 8'h01);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_head", 8'(out_data), 8'(drain_exp[i]));
         tick();
      end
      chk("drained_empty", 8'(out_valid), 8'h00);

      // Simultaneous push/pop when full
      stop = 1'b1; tick();
      start = 1'b1; tick();
      repeat (RC) tick();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cpu_out = 8'h80 | 8'(i);
         tick();
      end
      out_ready = 1'b1; cpu_out = 8'h8C;
      tick();
      chk("pushpop_no_ovf", 8'(overflow), 8'h00);
      cpu_out = 8'h00; out_ready = 1'b0;
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("pushpop_drain", 8'(out_data), 8'(full_exp[i]));
         tick();
      end

      // Randomized operation
      for (int n = 0; n < 400; n++) begin
         cpu_out   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         stop      = ($urandom_range(0, 39) == 0);
         start     = ($urandom_range(0, 7) == 0);
         load_valid = ($urandom_range(0, 3) == 0);
         load_addr = 6'($urandom);
         load_data = 6'($urandom);
         tick();
      end
      cpu_out = 8'h00; out_ready = 1'b1;
      stop = 1'b1; tick();
      repeat (DEPTH + 1) tick();

`ifdef CPU_MEM_SERVER_WATCHDOG_EN
      // Watchdog expiry and clearing on next start
      start = 1'b1; tick();
      repeat (RC) tick();
      repeat (MAXC - 1) tick();
      chk("wd_still_running", 8'(running), 8'h01);
      tick();
      chk("wd_idle", 8'(running), 8'h00);
      chk("wd_timeout", 8'(timeout), 8'h01);
      start = 1'b1; tick();
      chk("wd_timeout_clr", 8'(timeout), 8'h00);
      stop = 1'b1; tick();
`endif

      // Asynchronous reset in the middle of a run
      start = 1'b1; tick();
      repeat (RC) tick();
      cpu_out = 8'h91; out_ready = 1'b0;
      tick();
      cpu_out = 8'h00;
      chk("pre_areset_running", 8'(running), 8'h01);
      #2 reset_n = 1'b0;
      #1;
      model_reset();
      chk("areset_cpu_reset", 8'(cpu_reset), 8'h01);
      chk("areset_running", 8'(running), 8'h00);
      chk("areset_out_valid", 8'(out_valid), 8'h00);
      chk("areset_out_data", 8'(out_data), 8'h00);
      @(posedge clk); #1;
      check_all();
      reset_n = 1'b1;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cpu_mem_server.md
# cpu_mem_server

Companion stage to the 6-bit TinyTapeout accumulator CPU. It consumes the CPU's 8-bit output bus and produces the CPU's 6-bit memory-input bus.
- Serves instruction/operand fetches combinationally from a 64×6 loadable program store.
- Captures tagged output words (bus bits [7:6] = 2'b10) into a small FIFO drained over ready/valid.
- Sequences the CPU's active-high reset so programs load while the CPU is held, then run.

## Interface
- `FIFO_DEPTH`, default 4: output-capture FIFO entries (power of two, ≥2).
- `RESET_CYCLES`, default 4: cycles `cpu_reset` stays asserted after `start`, before release (≥1).
- `MAX_RUN_CYCLES`, default 1023: watchdog budget in RUN; only with the watchdog macro.
- `clk`, in, 1: single clock; the CPU runs on the same clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cpu_out`, in, 8: CPU output bus; [7:6]=00 → [5:0] is a fetch address; [7:6]=10 → [5:0] is an output value.
- `cpu_mem`, out, 6: data to the CPU memory input.
- `cpu_reset`, out, 1: active-high reset to the CPU.
- `load_valid`, in, 1: program-store write request.
- `load_ready`, out, 1: high only in IDLE.
- `load_addr`, in, 6: write address.
- `load_data`, in, 6: write data.
- `start`, in, 1: single-cycle pulse; begin a run.
- `stop`, in, 1: single-cycle pulse; abort a run.
- `out_valid`, out, 1: FIFO not empty.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_data`, out, 6: FIFO head.
- `running`, out, 1: state is RUN.
- `overflow`, out, 1: sticky; a capture was dropped.
- `timeout`, out, 1: sticky; the watchdog fired.

## Operation
- **FSM states:**
  - IDLE: `cpu_reset`=1; loads accepted.
  - HOLD: `cpu_reset`=1; counts `RESET_CYCLES`.
  - RUN: `cpu_reset`=0.
- **Transitions:**
  - IDLE→HOLD on `start`.
  - HOLD→RUN when the hold counter reaches `RESET_CYCLES`-1.
  - RUN→IDLE on `stop` or on watchdog expiry.
  - `stop` in HOLD → IDLE.
  - `start` outside IDLE is ignored.
- **Load:** a write occurs when `load_valid && load_ready`; `mem[load_addr] <= load_data`. The program store is not cleared by reset (contents undefined after power-up).
- **Fetch:** `cpu_mem = mem[cpu_out[5:0]]` combinationally whenever `cpu_out[7:6]==2'b00`; otherwise `cpu_mem` = 6'h00.
- **Capture:**
  - In RUN, every cycle with `cpu_out[7:6]==2'b10` pushes `cpu_out[5:0]`.
  - Tags 01 and 11 are ignored.
  - Captures are ignored outside RUN.
- **Push when full:** the value is dropped and `overflow` is set. Exception: a simultaneous pop (`out_valid && out_ready`) frees the slot, so the push succeeds.
- **Empty-FIFO push:** `out_valid` rises the next cycle; there is no bypass.
- **Pointers:** wrap modulo `FIFO_DEPTH`. An extra wrap bit distinguishes full from empty.
- **Sticky flags:** `overflow` and `timeout` clear only on the IDLE→HOLD transition (`start`) or on `reset_n`.
- **FIFO contents** persist across runs until drained; `start` does not flush.

## Timing
- **Reset values (`reset_n` low):**
  - state = IDLE.
  - `cpu_reset`=1, `load_ready`=1, `running`=0.
  - `out_valid`=0, `out_data`=0 (FIFO emptied).
  - `overflow`=0, `timeout`=0.
  - `cpu_mem` follows the combinational rule.
- **Fetch latency:** 0 cycles. The CPU changes the address on edge k and samples `cpu_mem` on edge k+1, so a registered read is forbidden.
- **Load write:** lands on the accepting edge; a fetch of that address sees the new data the cycle after.
- **`start` at edge k:**
  - `cpu_reset` stays 1 through edge k+`RESET_CYCLES`.
  - `running`=1 from edge k+`RESET_CYCLES`.
  - The CPU's first un-reset edge is k+`RESET_CYCLES`+1.
- **Capture:** the tagged cycle at edge k gives `out_valid`=1 after edge k+1.
- **`stop` at edge k:** `cpu_reset`=1 after edge k. A tag present in the same cycle as `stop` is still captured.
- **Async reset mid-run:** all state is abandoned immediately and `cpu_reset` asserts asynchronously.

## Configuration
- `CPU_MEM_SERVER_WATCHDOG_EN` defined:
  - A counter clears on entering RUN and increments each RUN cycle.
  - When it reaches `MAX_RUN_CYCLES`, the FSM goes RUN→IDLE and sets `timeout`.
  - A `stop` in the expiry cycle also sets `timeout`.
- Undefined: no counter, `MAX_RUN_CYCLES` unused, `timeout` tied 0; runs end only on `stop` or reset.

## Structure
- Shared package `cpu_mem_server_pkg` holds:
  - state enum {IDLE, HOLD, RUN};
  - bus tag constants TAG_ADDR=2'b00 and TAG_OUT=2'b10;
  - `CPU_WORD_W`=6.
- One sub-module `cpu_mem_server_fifo`: synchronous FIFO, parameter `DEPTH`, push/pop/full/empty. It has no overflow logic; overflow is decided in the parent.
- The program store and FSM stay in the top level.

## Test plan
- **Reset:** `reset_n` low → `cpu_reset`=1, `load_ready`=1, `out_valid`=0, `overflow`=0, `timeout`=0.
- **Load then fetch:** load mem[7]=6'h2A; drive `cpu_out`=8'h07 → `cpu_mem`=6'h2A in the same cycle. Drive `cpu_out`=8'h87 → `cpu_mem`=0.
- **Reset sequencing:** `RESET_CYCLES`=4, `start` at edge 10 → `cpu_reset` low from edge 14, `running`=1. `stop` at edge 20 → `cpu_reset`=1 at edge 21.
- **Capture and backpressure:** in RUN, with `out_ready`=0, drive tags 8'h85, 8'h93, 8'h81, 8'hBF, 8'h80, one per cycle. Expected: FIFO holds 05, 13, 01, 3F; the fifth is dropped; `overflow`=1. Then drain → 05, 13, 01, 3F in order.
- **Simultaneous push/pop when full:** full FIFO, `out_ready`=1 with tag 8'h8C in the same cycle → no overflow; 0C becomes the tail.
- **Watchdog** (macro on, `MAX_RUN_CYCLES`=15): no `stop` → FSM returns to IDLE 15 cycles after entering RUN, `timeout`=1. Next `start` → `timeout`=0.
